// File: rtl/cp0_exc_if.sv
// cp0_exc_if: M-stage exception flags, MTC0/MFC0 port and CP0 status outputs.
// Latency: wires only; no storage.
// Backpressure: none; master is the pipeline, slave is the CP0 block.
interface cp0_exc_if;
    logic        instr_validM;
    logic [31:0] pcM;
    logic        delayslotM;
    logic        syscallM;
    logic        breakM;
    logic        eretM;
    logic        invalidM;
    logic        overflowM;
    logic        adel_ifM;
    logic        adel_dM;
    logic        ades_dM;
    logic [31:0] bad_addrM;
    logic [5:0]  ext_int;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] epc_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;

    modport master (
        output instr_validM, pcM, delayslotM, syscallM, breakM, eretM, invalidM,
               overflowM, adel_ifM, adel_dM, ades_dM, bad_addrM, ext_int,
               cp0_we, cp0_waddr, cp0_raddr, cp0_wdata,
        input  cp0_rdata, flush, new_pc, epc_o, status_o, cause_o
    );

    modport slave (
        input  instr_validM, pcM, delayslotM, syscallM, breakM, eretM, invalidM,
               overflowM, adel_ifM, adel_dM, ades_dM, bad_addrM, ext_int,
               cp0_we, cp0_waddr, cp0_raddr, cp0_wdata,
        output cp0_rdata, flush, new_pc, epc_o, status_o, cause_o
    );
endinterface

// File: rtl/cp0_exc.sv
// cp0_exc: CP0 registers and precise-exception resolver at M; define CP0_TIMER_INT_EN for Count/Compare timer interrupt.
// Latency: flush/new_pc/cp0_rdata combinational in the M cycle; register updates land at the next edge.
// Backpressure: none; ordering of MTC0->MFC0 and stalls are the pipeline's responsibility.
module cp0_exc #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic     clk,
    input  logic     rst,
    cp0_exc_if.slave bus
);
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic [5:0]  cause_hw;
    logic [1:0]  cause_sw;
    logic [4:0]  cause_exc;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic        ti;

    logic [7:0]  cause_ip;
    logic [31:0] status_rd;
    logic [31:0] cause_rd;
    logic        int_req;
    logic        exc_take;
    logic        eret_take;
    logic        exc_flush;
    logic [4:0]  exc_code;
    logic        exc_badv;
    logic [31:0] badv_val;
    logic        wr;

    // The timer shares IP7 with the highest hardware line.
    assign cause_ip  = {cause_hw[5] | ti, cause_hw[4:0], cause_sw};
    assign status_rd = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
    assign cause_rd  = {cause_bd, ti, 14'd0, cause_ip, 1'b0, cause_exc, 2'b00};

    assign int_req = status_ie & ~status_exl & (|(cause_ip & status_im)) & bus.instr_validM;

    always_comb begin
        exc_take = 1'b1;
        exc_code = EXC_INT;
        exc_badv = 1'b0;
        badv_val = bus.pcM;
        if (!bus.instr_validM) begin
            exc_take = 1'b0;
        end else if (int_req) begin
            exc_code = EXC_INT;
        end else if (bus.adel_ifM) begin
            exc_code = EXC_ADEL;
            exc_badv = 1'b1;
            badv_val = bus.pcM;
        end else if (bus.invalidM) begin
            exc_code = EXC_RI;
        end else if (bus.overflowM) begin
            exc_code = EXC_OV;
        end else if (bus.syscallM) begin
            exc_code = EXC_SYS;
        end else if (bus.breakM) begin
            exc_code = EXC_BP;
        end else if (bus.adel_dM) begin
            exc_code = EXC_ADEL;
            exc_badv = 1'b1;
            badv_val = bus.bad_addrM;
        end else if (bus.ades_dM) begin
            exc_code = EXC_ADES;
            exc_badv = 1'b1;
            badv_val = bus.bad_addrM;
        end else begin
            exc_take = 1'b0;
        end
    end

    assign eret_take = bus.instr_validM & bus.eretM & ~exc_take;
    assign exc_flush = exc_take | eret_take;
    // An excepting or returning instruction never commits its own MTC0.
    assign wr        = bus.cp0_we & ~exc_flush;

    assign bus.flush    = exc_flush & ~rst;
    assign bus.new_pc   = exc_take ? EXC_VECTOR : epc;
    assign bus.epc_o    = epc;
    assign bus.status_o = status_rd;
    assign bus.cause_o  = cause_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            status_im  <= STATUS_RST[15:8];
            status_exl <= STATUS_RST[1];
            status_ie  <= STATUS_RST[0];
            cause_bd   <= 1'b0;
            cause_hw   <= 6'd0;
            cause_sw   <= 2'd0;
            cause_exc  <= 5'd0;
            epc        <= 32'd0;
            badvaddr   <= 32'd0;
        end else begin
            cause_hw <= bus.ext_int;
            if (exc_take) begin
                status_exl <= 1'b1;
                cause_exc  <= exc_code;
                cause_bd   <= bus.delayslotM;
                epc        <= bus.delayslotM ? bus.pcM - 32'd4 : bus.pcM;
                if (exc_badv) begin
                    badvaddr <= badv_val;
                end
            end else if (eret_take) begin
                status_exl <= 1'b0;
            end else if (wr) begin
                case (bus.cp0_waddr)
                    REG_STATUS: begin
                        status_im  <= bus.cp0_wdata[15:8];
                        status_exl <= bus.cp0_wdata[1];
                        status_ie  <= bus.cp0_wdata[0];
                    end
                    REG_CAUSE: cause_sw <= bus.cp0_wdata[9:8];
                    REG_EPC:   epc      <= bus.cp0_wdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef CP0_TIMER_INT_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 32'd0;
            compare <= 32'd0;
            tick    <= 1'b0;
            ti      <= 1'b0;
        end else begin
            tick <= ~tick;
            if (wr && bus.cp0_waddr == REG_COUNT) begin
                count <= bus.cp0_wdata;
            end else if (tick) begin
                count <= count + 32'd1;
            end
            if (wr && bus.cp0_waddr == REG_COMPARE) begin
                compare <= bus.cp0_wdata;
                ti      <= 1'b0;
            end else if (count == compare && compare != 32'd0) begin
                ti <= 1'b1;
            end
        end
    end
`else
    assign ti = 1'b0;
`endif

    always_comb begin
        case (bus.cp0_raddr)
            REG_BADVADDR: bus.cp0_rdata = badvaddr;
`ifdef CP0_TIMER_INT_EN
            REG_COUNT:    bus.cp0_rdata = count;
            REG_COMPARE:  bus.cp0_rdata = compare;
`endif
            REG_STATUS:   bus.cp0_rdata = status_rd;
            REG_CAUSE:    bus.cp0_rdata = cause_rd;
            REG_EPC:      bus.cp0_rdata = epc;
            default:      bus.cp0_rdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_cp0_exc.sv
// tb_cp0_exc: directed vectors for cp0_exc with a register-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_cp0_exc;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cp0_exc_if bus();
    cp0_exc dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: architectural register words ----------------
    logic        m_ok = 1'b0;
    logic [31:0] m_status, m_epc, m_badv, m_count, m_compare;
    logic        m_bd, m_ti;
    logic [4:0]  m_code;
    logic [1:0]  m_sw;
    logic [5:0]  m_hw;
    int          m_edges;

    function automatic logic [31:0] m_cause();
        logic [31:0] c;
        c = 32'd0;
        c[31]    = m_bd;
        c[30]    = m_ti;
        c[15]    = m_hw[5] | m_ti;
        c[14:10] = m_hw[4:0];
        c[9:8]   = m_sw;
        c[6:2]   = m_code;
        return c;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_badv;
`ifdef CP0_TIMER_INT_EN
            5'd9:  return m_count;
            5'd11: return m_compare;
`endif
            5'd12: return m_status;
            5'd13: return m_cause();
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    // Scan the raised causes in priority order; the first one raised wins.
    task automatic m_resolve(output logic take, output logic [4:0] code,
                             output logic set_badv, output logic [31:0] badv);
        logic        raised [8];
        logic [4:0]  codes  [8];
        logic [31:0] cause;
        logic        intr;
        cause = m_cause();
        intr  = m_status[0] && !m_status[1] && ((cause[15:8] & m_status[15:8]) != 8'd0);
        raised = '{intr, bus.adel_ifM, bus.invalidM, bus.overflowM, bus.syscallM,
                   bus.breakM, bus.adel_dM, bus.ades_dM};
        codes  = '{5'h00, 5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05};
        take = 1'b0; code = 5'd0; set_badv = 1'b0; badv = 32'd0;
        if (bus.instr_validM) begin
            for (int i = 0; i < 8; i++) begin
                if (raised[i] && !take) begin
                    take = 1'b1;
                    code = codes[i];
                    if (i == 1) begin set_badv = 1'b1; badv = bus.pcM; end
                    if (i >= 6) begin set_badv = 1'b1; badv = bus.bad_addrM; end
                end
            end
        end
    endtask

    logic        u_take, u_sb, u_fl, u_we;
    logic [4:0]  u_code;
    logic [31:0] u_bv, u_oldc, u_oldk;

    always @(posedge clk) begin
        if (rst) begin
            m_ok = 1'b1;
            m_status = 32'h0040_0000; m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
            m_bd = 0; m_ti = 0; m_code = 0; m_sw = 0; m_hw = 0; m_edges = 0;
        end else if (m_ok) begin
            m_resolve(u_take, u_code, u_sb, u_bv);
            u_fl = u_take || (bus.instr_validM && bus.eretM);
            u_we = bus.cp0_we && !u_fl;
`ifdef CP0_TIMER_INT_EN
            m_edges++;
            u_oldc = m_count;
            u_oldk = m_compare;
            if (u_we && bus.cp0_waddr == 5'd11) begin m_compare = bus.cp0_wdata; m_ti = 1'b0; end
            else if (u_oldc == u_oldk && u_oldk != 0) m_ti = 1'b1;
            if (u_we && bus.cp0_waddr == 5'd9) m_count = bus.cp0_wdata;
            else if (m_edges % 2 == 0) m_count = u_oldc + 1;
`endif
            if (u_take) begin
                m_status[1] = 1'b1;
                m_code = u_code;
                m_bd   = bus.delayslotM;
                m_epc  = bus.delayslotM ? bus.pcM - 4 : bus.pcM;
                if (u_sb) m_badv = u_bv;
            end else if (u_fl) begin
                m_status[1] = 1'b0;
            end else if (u_we) begin
                case (bus.cp0_waddr)
                    5'd12: m_status = (bus.cp0_wdata & 32'h0000_FF03) | 32'h0040_0000;
                    5'd13: m_sw = bus.cp0_wdata[9:8];
                    5'd14: m_epc = bus.cp0_wdata;
                    default: ;
                endcase
            end
            m_hw = bus.ext_int;
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    logic        c_take, c_sb, c_fl;
    logic [4:0]  c_code;
    logic [31:0] c_bv;

    always @(negedge clk) begin
        if (m_ok) begin
            m_resolve(c_take, c_code, c_sb, c_bv);
            c_fl = !rst && (c_take || (bus.instr_validM && bus.eretM));
            chk("model_flush", {31'd0, bus.flush}, {31'd0, c_fl});
            if (c_fl) chk("model_new_pc", bus.new_pc, c_take ? VEC : m_epc);
            chk("model_status", bus.status_o, m_status);
            chk("model_cause", bus.cause_o, m_cause());
            chk("model_epc", bus.epc_o, m_epc);
            chk("model_rdata", bus.cp0_rdata, m_read(bus.cp0_raddr));
        end
    end

    // ---------------- directed stimulus ----------------
    int rs_k = 0;

    function automatic logic [4:0] rd_seq(input int k);
        case (k % 8)
            0: return 5'd8;  1: return 5'd9;  2: return 5'd11; 3: return 5'd12;
            4: return 5'd13; 5: return 5'd14; 6: return 5'd0;  default: return 5'd31;
        endcase
    endfunction

    task automatic clear();
        bus.instr_validM = 0; bus.pcM = 0; bus.delayslotM = 0;
        bus.syscallM = 0; bus.breakM = 0; bus.eretM = 0; bus.invalidM = 0;
        bus.overflowM = 0; bus.adel_ifM = 0; bus.adel_dM = 0; bus.ades_dM = 0;
        bus.bad_addrM = 0; bus.cp0_we = 0; bus.cp0_waddr = 0; bus.cp0_wdata = 0;
        bus.cp0_raddr = rd_seq(rs_k);
        rs_k++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clear();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cyc();
        bus.instr_validM = 1; bus.cp0_we = 1; bus.cp0_waddr = a; bus.cp0_wdata = d;
    endtask

    typedef struct {
        logic [6:0]  f;      // adel_if, invalid, ov, sys, brk, adel_d, ades_d
        logic [31:0] pc;
        logic [31:0] bad;
        logic [4:0]  code;
        logic [31:0] badv;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{7'b1000001, 32'h1000_0002, 32'h0000_0044, 5'h04, 32'h1000_0002};
        tbl[1] = '{7'b0110000, 32'h0000_0100, 32'h0000_0000, 5'h0A, 32'h1000_0002};
        tbl[2] = '{7'b0001100, 32'h0000_0200, 32'h0000_0000, 5'h08, 32'h1000_0002};
        tbl[3] = '{7'b0000101, 32'h0000_0300, 32'h0000_0044, 5'h09, 32'h1000_0002};
        tbl[4] = '{7'b0000001, 32'h0000_0400, 32'h0000_0047, 5'h05, 32'h0000_0047};
        tbl[5] = '{7'b0000011, 32'h0000_0500, 32'h0000_0101, 5'h04, 32'h0000_0101};

        rst = 1; clear(); bus.ext_int = 6'd0;
        cyc(); cyc();
        @(negedge clk);
        chk("reset_status", bus.status_o, 32'h0040_0000);
        chk("reset_cause", bus.cause_o, 32'h0);
        chk("reset_epc", bus.epc_o, 32'h0);
        chk("reset_flush", {31'd0, bus.flush}, 32'h0);
        cyc(); rst = 0;

        // syscall
        cyc();
        bus.instr_validM = 1; bus.pcM = 32'hBFC0_0100; bus.syscallM = 1;
        @(negedge clk);
        chk("sys_flush", {31'd0, bus.flush}, 32'h1);
        chk("sys_new_pc", bus.new_pc, VEC);
        cyc();
        @(negedge clk);
        chk("sys_epc", bus.epc_o, 32'hBFC0_0100);
        chk("sys_code", {27'd0, bus.cause_o[6:2]}, 32'h08);
        chk("sys_exl", {31'd0, bus.status_o[1]}, 32'h1);

        // overflow beats load misalignment in a delay slot
        cyc();
        bus.instr_validM = 1; bus.pcM = 32'hBFC0_0204; bus.delayslotM = 1;
        bus.overflowM = 1; bus.adel_dM = 1; bus.bad_addrM = 32'h8000_0003;
        @(negedge clk);
        chk("ov_flush", {31'd0, bus.flush}, 32'h1);
        cyc(); bus.cp0_raddr = 5'd8;
        @(negedge clk);
        chk("ov_code", {27'd0, bus.cause_o[6:2]}, 32'h0C);
        chk("ov_bd", {31'd0, bus.cause_o[31]}, 32'h1);
        chk("ov_epc", bus.epc_o, 32'hBFC0_0200);
        chk("ov_badv", bus.cp0_rdata, 32'h0);

        // priority table
        for (int i = 0; i < 6; i++) begin
            cyc();
            bus.instr_validM = 1; bus.pcM = tbl[i].pc; bus.bad_addrM = tbl[i].bad;
            {bus.adel_ifM, bus.invalidM, bus.overflowM, bus.syscallM,
             bus.breakM, bus.adel_dM, bus.ades_dM} = tbl[i].f;
            @(negedge clk);
            chk("tbl_flush", {31'd0, bus.flush}, 32'h1);
            cyc(); bus.cp0_raddr = 5'd8;
            @(negedge clk);
            chk("tbl_code", {27'd0, bus.cause_o[6:2]}, {27'd0, tbl[i].code});
            chk("tbl_badv", bus.cp0_rdata, tbl[i].badv);
        end

        // flags on a bubble are ignored; BadVAddr is read-only
        cyc();
        bus.syscallM = 1; bus.invalidM = 1;
        @(negedge clk);
        chk("bubble_flush", {31'd0, bus.flush}, 32'h0);
        mtc0(5'd8, 32'hFFFF_FFFF);
        cyc(); bus.cp0_raddr = 5'd8;
        @(negedge clk);
        chk("badv_ro", bus.cp0_rdata, 32'h0000_0101);

        // hardware interrupt, then blocked while EXL=1
        mtc0(5'd12, 32'h0000_0401);
        cyc();
        @(negedge clk);
        chk("int_status", bus.status_o, 32'h0040_0401);
        bus.ext_int = 6'b000001;
        cyc();
        @(negedge clk);
        chk("int_ip2", {31'd0, bus.cause_o[10]}, 32'h1);
        cyc();
        bus.instr_validM = 1; bus.pcM = 32'hBFC0_0300;
        @(negedge clk);
        chk("int_flush", {31'd0, bus.flush}, 32'h1);
        chk("int_new_pc", bus.new_pc, VEC);
        cyc();
        bus.instr_validM = 1; bus.pcM = 32'hBFC0_0304;
        @(negedge clk);
        chk("int_code", {27'd0, bus.cause_o[6:2]}, 32'h00);
        chk("int_epc", bus.epc_o, 32'hBFC0_0300);
        chk("int_blocked", {31'd0, bus.flush}, 32'h0);
        bus.ext_int = 6'd0;

        // ERET with a simultaneous EPC write that must be dropped
        mtc0(5'd14, 32'hBFC0_0123);
        cyc();
        @(negedge clk);
        chk("eret_epc_set", bus.epc_o, 32'hBFC0_0123);
        mtc0(5'd14, 32'hDEAD_BEEF);
        bus.eretM = 1;
        @(negedge clk);
        chk("eret_flush", {31'd0, bus.flush}, 32'h1);
        chk("eret_new_pc", bus.new_pc, 32'hBFC0_0123);
        cyc();
        @(negedge clk);
        chk("eret_exl", {31'd0, bus.status_o[1]}, 32'h0);
        chk("eret_epc_kept", bus.epc_o, 32'hBFC0_0123);

        // reset wins over a same-cycle exception
        cyc();
        bus.instr_validM = 1; bus.invalidM = 1; bus.pcM = 32'hBFC0_0400; rst = 1;
        @(negedge clk);
        chk("rst_flush", {31'd0, bus.flush}, 32'h0);
        cyc(); rst = 0;
        @(negedge clk);
        chk("rst_status", bus.status_o, 32'h0040_0000);
        chk("rst_cause", bus.cause_o, 32'h0);
        chk("rst_epc", bus.epc_o, 32'h0);

`ifdef CP0_TIMER_INT_EN
        begin
            logic seen;
            mtc0(5'd11, 32'd5);
            mtc0(5'd9, 32'd0);
            mtc0(5'd12, 32'h0000_8001);
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                cyc();
                @(negedge clk);
                seen = bus.cause_o[30];
            end
            chk("ti_set", {31'd0, seen}, 32'h1);
            cyc();
            bus.instr_validM = 1; bus.pcM = 32'hBFC0_0500;
            @(negedge clk);
            chk("ti_flush", {31'd0, bus.flush}, 32'h1);
            mtc0(5'd11, 32'd5);
            cyc();
            @(negedge clk);
            chk("ti_cleared", {31'd0, bus.cause_o[30]}, 32'h0);
        end
`endif

        cyc(); cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
